// File: rtl/rms_pkg.sv
// Shared definitions for the RMS window command generator.
// Holds the default sample width and window depth, the command codes sent to
// the RMS engine, the controller state encoding and the window-length clamp.
package rms_pkg;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 64;

    typedef enum logic [1:0] {
        CMD_ADD    = 2'd0,
        CMD_SUB    = 2'd1,
        CMD_ADDOUT = 2'd2,
        CMD_FLUSH  = 2'd3
    } cmd_e;

    typedef enum logic {
        StIdle,
        StSubPend
    } state_e;

    // 0 means a one-sample window; anything beyond the buffer is capped at it.
    function automatic logic [6:0] clamp_winlen(input logic [6:0] wl, input logic [6:0] depth);
        if (wl == 7'd0) begin
            return 7'd1;
        end
        if (wl > depth) begin
            return depth;
        end
        return wl;
    endfunction

endpackage

// File: rtl/rms_window_tx_if.sv
// Sample/command bus between upstream producer, rms_window_tx and the RMS engine.
//   pushin/Xin/flushin/winlen : upstream sample stream and window length
//   stopout                   : backpressure to upstream
//   pushout/cmdout/Xout       : command stream toward the RMS engine
// master = upstream/engine side, slave = rms_window_tx.
interface rms_window_tx_if #(
    parameter int unsigned W = rms_pkg::W
) ();

    logic         pushin;
    logic [W-1:0] Xin;
    logic         flushin;
    logic [6:0]   winlen;
    logic         stopout;
    logic         pushout;
    logic [1:0]   cmdout;
    logic [W-1:0] Xout;

    modport master (
        output pushin, Xin, flushin, winlen,
        input  stopout, pushout, cmdout, Xout
    );

    modport slave (
        input  pushin, Xin, flushin, winlen,
        output stopout, pushout, cmdout, Xout
    );

endinterface

// File: rtl/rms_winbuf.sv
// Circular sample buffer for the RMS window.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address, wdata_i : write data
//   raddr_i : asynchronous read address, rdata_o : read data
// Contents are not reset; only positions written since reset are ever read.
module rms_winbuf #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rms_window_tx.sv
// Sliding-window command generator for a running RMS engine.
// Each accepted sample becomes ADD / ADDOUT / FLUSH; once the window is full a
// SUB of the sample leaving the window is issued first, which takes a second
// cycle (stopout held for that cycle).
//   clk, rst : clock and asynchronous active-high reset
//   bus      : rms_window_tx_if slave (sample in, command out)
module rms_window_tx #(
    parameter int unsigned W     = rms_pkg::W,
    parameter int unsigned DEPTH = rms_pkg::DEPTH
) (
    input logic            clk,
    input logic            rst,
    rms_window_tx_if.slave bus
);

    import rms_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    state_e        state_q, state_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [6:0]    n_q, n_d, n_eff;
    logic [AW-1:0] wptr_q, wptr_d, old_addr;
    logic          pushout_q, pushout_d;
    cmd_e          cmd_q, cmd_d;
    logic [W-1:0]  xout_q, xout_d;
    cmd_e          pend_cmd_q, pend_cmd_d;
    logic [W-1:0]  pend_x_q, pend_x_d;
    logic [W-1:0]  old_x;
    logic          stop, accept, need_sub, we;

    // Window length only follows winlen while the window is empty.
    assign n_eff    = (cnt_q == 7'd0) ? clamp_winlen(bus.winlen, 7'(DEPTH)) : n_q;
    assign n_d      = n_eff;
    // N = DEPTH wraps to wptr itself; the read returns the old value before the write.
    assign old_addr = wptr_q - AW'(n_eff);
    assign accept   = bus.pushin && !stop;
    assign need_sub = accept && (cnt_q == n_eff);

    rms_winbuf #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_winbuf (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wptr_q),
        .wdata_i (bus.Xin),
        .raddr_i (old_addr),
        .rdata_o (old_x)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (need_sub) state_d = StSubPend;
            StSubPend: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        stop = 1'b0;
        if (state_q == StSubPend) begin
            stop = 1'b1;
        end
    end

    // Datapath next state.
    always_comb begin
        cnt_d      = cnt_q;
        wptr_d     = wptr_q;
        pushout_d  = 1'b0;
        cmd_d      = cmd_q;
        xout_d     = xout_q;
        pend_cmd_d = pend_cmd_q;
        pend_x_d   = pend_x_q;
        we         = 1'b0;
        if (state_q == StSubPend) begin
            pushout_d = 1'b1;
            cmd_d     = pend_cmd_q;
            xout_d    = pend_x_q;
        end else if (accept) begin
            we        = 1'b1;
            wptr_d    = wptr_q + AW'(1);
            pushout_d = 1'b1;
            if (need_sub) begin
                cmd_d    = CMD_SUB;
                xout_d   = old_x;
                pend_x_d = bus.Xin;
                if (bus.flushin) begin
                    pend_cmd_d = CMD_FLUSH;
                    cnt_d      = 7'd0;
                end else begin
                    pend_cmd_d = CMD_ADDOUT;
                end
            end else if (bus.flushin) begin
                cmd_d  = CMD_FLUSH;
                xout_d = bus.Xin;
                cnt_d  = 7'd0;
            end else if (cnt_q == n_eff - 7'd1) begin
                cmd_d  = CMD_ADDOUT;
                xout_d = bus.Xin;
                cnt_d  = n_eff;
            end else begin
                cmd_d  = CMD_ADD;
                xout_d = bus.Xin;
                cnt_d  = cnt_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= 7'd0;
            n_q        <= 7'd1;
            wptr_q     <= '0;
            pushout_q  <= 1'b0;
            cmd_q      <= CMD_ADD;
            xout_q     <= '0;
            pend_cmd_q <= CMD_ADD;
            pend_x_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            wptr_q     <= wptr_d;
            pushout_q  <= pushout_d;
            cmd_q      <= cmd_d;
            xout_q     <= xout_d;
            pend_cmd_q <= pend_cmd_d;
            pend_x_q   <= pend_x_d;
        end
    end

    assign bus.stopout = stop;
    assign bus.pushout = pushout_q;
    assign bus.cmdout  = cmd_q;
    assign bus.Xout    = xout_q;

endmodule

// File: tb/tb_rms_window_tx.sv
// Bench for rms_window_tx: directed scenarios followed by random traffic, all
// checked against a window model that keeps the full accepted-sample history
// and a queue of expected commands.
module tb_rms_window_tx;

    import rms_pkg::*;

    typedef struct {
        logic [1:0]   cmd;
        logic [W-1:0] x;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   pushes_seen = 0;
    int   drops = 0;

    cmd_t         exp_q[$];
    logic [W-1:0] hist[$];
    int           cnt_m = 0;
    int           n_m = 1;

    rms_window_tx_if #(.W(W)) bus ();

    rms_window_tx #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Window rules applied to one accepted sample.
    task automatic model_accept(input logic [W-1:0] x, input logic f, input logic [6:0] wl);
        int req;
        if (cnt_m == 0) begin
            req = int'(wl);
            n_m = (req == 0) ? 1 : ((req > int'(DEPTH)) ? int'(DEPTH) : req);
        end
        if (cnt_m == n_m) begin
            exp_q.push_back('{CMD_SUB, hist[hist.size() - n_m]});
            exp_q.push_back('{f ? CMD_FLUSH : CMD_ADDOUT, x});
            if (f) cnt_m = 0;
        end else if (f) begin
            exp_q.push_back('{CMD_FLUSH, x});
            cnt_m = 0;
        end else begin
            cnt_m++;
            exp_q.push_back('{(cnt_m == n_m) ? CMD_ADDOUT : CMD_ADD, x});
        end
        hist.push_back(x);
    endtask

    // One clock cycle: drive inputs, check stopout, then check the registered outputs.
    task automatic cycle(input logic p, input logic [W-1:0] x, input logic f,
                         input logic [6:0] wl);
        logic exp_stop;
        cmd_t e;
        bus.pushin  = p;
        bus.Xin     = x;
        bus.flushin = f;
        bus.winlen  = wl;
        #1;
        exp_stop = (exp_q.size() != 0);
        chk("stopout", 64'(bus.stopout), 64'(exp_stop));
        if (p && exp_stop) drops++;
        if (p && !exp_stop) model_accept(x, f, wl);
        @(posedge clk);
        #1;
        chk("pushout", 64'(bus.pushout), 64'(exp_q.size() != 0));
        if (bus.pushout === 1'b1) pushes_seen++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("cmdout", 64'(bus.cmdout), 64'(e.cmd));
            chk("Xout", 64'(bus.Xout), 64'(e.x));
        end
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 7'd0);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_pushout", 64'(bus.pushout), 64'd0);
        chk("rst_stopout", 64'(bus.stopout), 64'd0);
        chk("rst_cmdout", 64'(bus.cmdout), 64'd0);
        chk("rst_Xout", 64'(bus.Xout), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        hist.delete();
        cnt_m = 0;
        n_m   = 1;
    endtask

    initial begin
        int base;
        logic [6:0] wl;
        bus.pushin  = 1'b0;
        bus.Xin     = '0;
        bus.flushin = 1'b0;
        bus.winlen  = 7'd0;
        #2;
        do_reset();

        // Fill, N=4.
        for (int i = 1; i <= 4; i++) cycle(1'b1, W'(i), 1'b0, 7'd4);
        // Slide: SUB 1 then ADDOUT 5, one stall cycle.
        cycle(1'b1, W'(5), 1'b0, 7'd4);
        idle();
        // Push while stalled is dropped.
        cycle(1'b1, W'(6), 1'b0, 7'd4);
        cycle(1'b1, W'(77), 1'b0, 7'd4);
        // Flush with full window, then a fresh window (N=2).
        cycle(1'b1, W'(9), 1'b1, 7'd4);
        idle();
        cycle(1'b1, W'(10), 1'b0, 7'd2);
        cycle(1'b1, W'(11), 1'b1, 7'd2);

        // Wrap, N=64, 200 samples.
        base = pushes_seen;
        for (int k = 0; k < 200; k++) begin
            cycle(1'b1, W'(k), 1'b0, 7'd64);
            if (exp_q.size() != 0) idle();
        end
        chk("wrap_push_count", 64'(pushes_seen - base), 64'd336);
        cycle(1'b1, W'(500), 1'b1, 7'd64);
        idle();

        // winlen 0 acts as 1; a change mid-window waits for the flush.
        cycle(1'b1, W'(20), 1'b0, 7'd0);
        cycle(1'b1, W'(21), 1'b0, 7'd3);
        idle();
        cycle(1'b1, W'(22), 1'b1, 7'd3);
        idle();
        for (int i = 23; i <= 26; i++) begin
            cycle(1'b1, W'(i), 1'b0, 7'd3);
            if (exp_q.size() != 0) idle();
        end
        cycle(1'b1, W'(27), 1'b1, 7'd1);
        idle();

        // Reset while a SUB is pending.
        cycle(1'b1, W'(30), 1'b0, 7'd1);
        cycle(1'b1, W'(31), 1'b0, 7'd1);
        do_reset();
        cycle(1'b1, W'(40), 1'b0, 7'd1);

        // Random traffic, including pushes during stalls.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 8) wl = 7'($urandom_range(0, 6));
            else wl = 7'($urandom_range(60, 64));
            cycle(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 15) == 0), wl);
        end
        idle();
        idle();

        $display("protocol violations (push while stopout) injected: %0d", drops);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rms_window_tx.md
RMS_WINDOW_TX -- requirements
Module: rms_window_tx

Interface
REQ-001 Parameter: W, 32, sample width in bits.
REQ-002 Parameter: DEPTH, 64, maximum window length in samples; a power of two.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: pushin  input  1  upstream sample valid; the sample is accepted when pushin=1 and stopout=0.
REQ-006 Port: Xin  input  W  upstream sample value.
REQ-007 Port: flushin  input  1  qualified by pushin; marks the sample as the last of a record.
REQ-008 Port: winlen  input  7  window length N; legal values 1..64, and 0 is treated as 1.
REQ-009 Port: stopout  output  1  backpressure to upstream; while it is 1, no sample is accepted.
REQ-010 Port: pushout  output  1  command valid toward the RMS engine; at most one command per cycle.
REQ-011 Port: cmdout  output  2  command code: 0 ADD, 1 SUB, 2 ADDOUT, 3 FLUSH.
REQ-012 Port: Xout  output  W  sample value that accompanies cmdout.

Function
REQ-013 Every accepted sample shall be written to a circular buffer at wptr; wptr increments modulo DEPTH.
REQ-014 N shall be latched from winlen only while the window count cnt=0; winlen changes at any other time shall be ignored.
REQ-015 Outputs shall be registered; a command for a sample accepted in cycle t shall appear no earlier than t+1.
REQ-016 When an accepted sample has flushin=0 and cnt<N-1, the block shall emit cmd 0 with Xout equal to the sample at t+1, and cnt shall increment.
REQ-017 When an accepted sample has flushin=0 and cnt=N-1, the block shall emit cmd 2 with the sample at t+1, and cnt shall become N.
REQ-018 When an accepted sample has flushin=0 and cnt=N, the SUB state shall apply:
  - t+1: emit cmd 1 with Xout = buf[(wptr_at_accept - N) mod DEPTH];
  - t+2: emit cmd 2 with the new sample;
  - cnt stays N.
REQ-019 When an accepted sample has flushin=1 and cnt<N, the block shall emit cmd 3 with the sample at t+1, and cnt shall become 0.
REQ-020 When an accepted sample has flushin=1 and cnt=N, the block shall emit cmd 1 with the oldest sample at t+1, then cmd 3 with the sample at t+2, and cnt shall become 0.
REQ-021 The state machine shall have two states:
  - IDLE: stopout=0.
  - SUB_PEND: entered on an accept that needs a subtract; stopout=1 combinationally; returns to IDLE after emitting the second command.
REQ-022 pushin asserted while stopout=1 shall be dropped with no side effect; verification shall flag it as a protocol error.
REQ-023 When flushin=1 is accepted, wptr shall not reset.
REQ-024 For N=1, every sample after the first shall produce SUB of the previous sample followed by ADDOUT of the new sample.
REQ-025 pushout shall be 0 in any cycle in which no command is issued.

Reset
REQ-026 Reset shall set pushout=0, cmdout=0, Xout=0, stopout=0, state=IDLE, cnt=0, wptr=0 and N=1; buffer contents need not be cleared.
REQ-027 Reset mid-sequence, including in SUB_PEND, shall abandon the pending command; the downstream engine shall be reset together with this block.

Structure
REQ-028 A shared package rms_pkg shall hold the command codes CMD_ADD, CMD_SUB, CMD_ADDOUT and CMD_FLUSH, plus DEPTH and W.
REQ-029 The design shall have one sub-module, rms_winbuf: a DEPTH x W register array with one write port and one asynchronous read port.

Verification
REQ-030 Fill with N=4, samples 1,2,3,4, one per cycle: cmds 0,0,0,2 with Xout 1,2,3,4; stopout stays 0.
REQ-031 Slide, N=4, then sample 5: cmd 1 Xout=1, then cmd 2 Xout=5; stopout=1 for exactly one cycle.
REQ-032 Flush with full window, N=4, then sample 9 with flushin=1: cmd 1 (oldest), then cmd 3 Xout=9; cnt=0; the next sample yields cmd 0.
REQ-033 Wrap, N=64, 200 samples k=0..199: each SUB carries k-64; pushout count = 200 + 136.
REQ-034 winlen driven to 0 and changed mid-window: 0 behaves as N=1; a change while cnt>0 takes effect only after the next flush.
REQ-035 Reset asserted in SUB_PEND: pushout=0 next cycle and stopout=0; a fresh sample then yields cmd 2 when N=1.
